// File: rtl/rv_core_pkg.sv
// Shared core types: XLEN, NOP encoding, fetch FSM states
// and the IF/ID pipeline register bundle.
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_gen.sv
// PC register with redirect/+4/hold mux and ROM range check.
// Ports: clk, rst_n, redirect_i, redirect_pc_i, advance_i, pc_o, in_range_o.
module pc_gen
  import rv_core_pkg::*;
#(
  parameter int unsigned     IMEM_SIZE = 10,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [XLEN-1:0] pc_o,
  output logic            in_range_o
);

  localparam logic [XLEN-3:0] LIMIT = IMEM_SIZE[XLEN-3:0];

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect_i: pc_d = word_align(redirect_pc_i);
      advance_i:  pc_d = pc_q + 32'd4;
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o       = pc_q;
  assign in_range_o = pc_q[XLEN-1:2] < LIMIT;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, ROM addressing, IF/ID register, RUN/DRAIN/HALT FSM.
// Ports: clk, rst_n, imem_addr/imem_data (ROM), redirect_valid/redirect_pc,
// out_valid/out_ready/out_instr/out_pc (to decode), halted,
// fetch_count (only with IF_FETCH_COUNT_EN).
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter int unsigned     IMEM_SIZE = 10,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
`ifdef IF_FETCH_COUNT_EN
  output logic [31:0]     fetch_count,
`endif
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  if_id_t          ifid_q, ifid_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] pc;
  logic            in_range;
  logic            fetch;
  logic            can_load;
  logic            fire;

  assign can_load = !ifid_q.valid || out_ready;
  assign fire     = ifid_q.valid && out_ready;

  pc_gen #(
    .IMEM_SIZE (IMEM_SIZE),
    .RESET_PC  (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_valid),
    .redirect_pc_i (redirect_pc),
    .advance_i     (fetch),
    .pc_o          (pc),
    .in_range_o    (in_range)
  );

  always_comb begin
    ifid_d   = ifid_q;
    state_d  = state_q;
    halted_d = 1'b0;
    fetch    = 1'b0;
    if (redirect_valid) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
      state_d      = ST_RUN;
    end else begin
      halted_d = (state_q == ST_HALT);
      unique case (state_q)
        ST_RUN: begin
          if (can_load && in_range) begin
            fetch  = 1'b1;
            ifid_d = '{instr: imem_data,
                       pc:    pc,
                       valid: 1'b1};
          end else if (can_load) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
            state_d      = ST_HALT;
          end else if (!in_range) begin
            // last instruction still stalled in the register
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fire) begin
            ifid_d.valid = 1'b0;
            ifid_d.instr = NOP_INSTR;
            state_d      = ST_HALT;
          end
        end
        ST_HALT: ifid_d.valid = 1'b0;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      ifid_q   <= '{instr: NOP_INSTR,
                    pc:    '0,
                    valid: 1'b0};
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ifid_q   <= ifid_d;
      halted_q <= halted_d;
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (fire && cnt_q != 32'hFFFF_FFFF)
      cnt_q <= cnt_q + 32'd1;
  end

  assign fetch_count = cnt_q;
`endif

  assign imem_addr = {2'b00, pc[XLEN-1:2]};
  assign out_valid = ifid_q.valid;
  assign out_instr = ifid_q.instr;
  assign out_pc    = ifid_q.pc;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random
// redirect/backpressure against a behavioural fetch model.
module tb_instr_fetch_unit;
  import rv_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, halted;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr, out_pc;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  always #5 clk = ~clk;

  logic [31:0] rom [16];
  assign imem_data = (imem_addr < 32'd10) ?
                     rom[imem_addr[3:0]] : 32'hDEAD_BEEF;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
`ifdef IF_FETCH_COUNT_EN
    .fetch_count    (fetch_count),
`endif
    .halted         (halted)
  );

  int nchecks = 0;
  int nerr    = 0;
  bit chk_en  = 1'b0;

  // behavioural model: PC, visible IF/ID contents, halted flag
  logic [31:0] m_pc, m_oi, m_opc, m_cnt;
  logic        m_ov, m_halt, m_lastredir;

  task automatic cmp(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               n, act, exp, $time);
    end
  endtask

  function automatic bit oor(input logic [31:0] p);
    return (p >> 2) >= 32'd10;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ov = 1'b0; m_oi = 32'h13;
    m_opc = 32'h0; m_halt = 1'b0; m_cnt = 32'h0;
    m_lastredir = 1'b0;
  endtask

  task automatic model_edge(input logic rv,
                            input logic [31:0] rp,
                            input logic rdy);
    bit idle;
    if (m_ov && rdy && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (rv) begin
      m_pc = rp & 32'hFFFF_FFFC;
      m_ov = 1'b0;
      m_oi = 32'h13;
      m_halt = 1'b0;
      m_lastredir = 1'b1;
    end else begin
      // halted: stuck past ROM end with nothing left to hand over
      idle = !m_lastredir && oor(m_pc) && !m_ov;
      if (m_ov && !rdy) begin
      end else if (!oor(m_pc)) begin
        m_oi  = rom[m_pc[5:2]];
        m_opc = m_pc;
        m_ov  = 1'b1;
        m_pc  = m_pc + 32'd4;
      end else begin
        m_ov = 1'b0;
        m_oi = 32'h13;
      end
      m_halt = idle;
      m_lastredir = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      cmp("out_instr", out_instr, m_oi);
      cmp("out_pc", out_pc, m_opc);
      cmp("halted", {31'b0, halted}, {31'b0, m_halt});
      cmp("imem_addr", imem_addr, m_pc >> 2);
`ifdef IF_FETCH_COUNT_EN
      cmp("fetch_count", fetch_count, m_cnt);
`endif
    end
  end

  task automatic step(input logic rv,
                      input logic [31:0] rp,
                      input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
    @(posedge clk);
    model_edge(rv, rp, rdy);
    @(negedge clk);
  endtask

  // asynchronous reset pulse placed off the clock edges
  task automatic do_reset();
    chk_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_valid", {31'b0, out_valid}, 32'h0);
    cmp("rst_instr", out_instr, 32'h13);
    cmp("rst_pc", out_pc, 32'h0);
    cmp("rst_halted", {31'b0, halted}, 32'h0);
    cmp("rst_addr", imem_addr, 32'h0);
`ifdef IF_FETCH_COUNT_EN
    cmp("rst_count", fetch_count, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  logic [31:0] rp;
  logic        rv, rdy;

  initial begin
    rom[0] = 15; rom[1] = 64; rom[2] = 89; rom[3] = 1;
    rom[4] = 73; rom[5] = 5;  rom[6] = 6;  rom[7] = 7;
    rom[8] = 8;  rom[9] = 9;
    for (int i = 10; i < 16; i++) rom[i] = 32'hBAD0_0000;
    model_reset();
    do_reset();

    // free run to the end of ROM
    for (int i = 1; i <= 13; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (i == 1) begin
        cmp("run_first", out_instr, 32'd15);
        cmp("run_first_pc", out_pc, 32'd0);
      end
      if (i == 10) begin
        cmp("run_last", out_instr, 32'd9);
        cmp("run_last_pc", out_pc, 32'd36);
      end
      if (i == 11) begin
        cmp("run_drop", {31'b0, out_valid}, 32'h0);
        cmp("run_nohalt", {31'b0, halted}, 32'h0);
      end
      if (i == 12)
        cmp("run_halt", {31'b0, halted}, 32'h1);
    end

    // redirect out of HALT
    step(1'b1, 32'h0, 1'b1);
    cmp("hr_halted", {31'b0, halted}, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    cmp("hr_first", out_instr, 32'd15);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    cmp("st_pre", out_instr, 32'd89);

    // three stalled cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0);
      cmp("st_instr", out_instr, 32'd89);
      cmp("st_pc", out_pc, 32'd8);
      cmp("st_addr", imem_addr, 32'd3);
    end
    step(1'b0, 32'h0, 1'b1);
    cmp("st_next", out_instr, 32'd1);
    cmp("st_next_pc", out_pc, 32'd12);

    // redirect while stalled on 64
    step(1'b1, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    cmp("rs_pre", out_instr, 32'd64);
    step(1'b1, 32'h13, 1'b0);
    cmp("rs_flush", {31'b0, out_valid}, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    cmp("rs_tgt", out_instr, 32'd73);
    cmp("rs_tgt_pc", out_pc, 32'd16);

    // random redirects and backpressure
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 9) == 0);
      rp  = ($urandom_range(0, 3) == 0) ?
            $urandom : $urandom_range(0, 55);
      rdy = ($urandom_range(0, 9) < 7);
      step(rv, rp, rdy);
    end

    // mid-run reset then restart
    step(1'b1, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    cmp("rr_first", out_instr, 32'd15);

    // full run, redirect to 0, rerun
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);
    cmp("rerun_halt", {31'b0, halted}, 32'h1);
`ifdef IF_FETCH_COUNT_EN
    cmp("count_20", fetch_count, 32'd20);
`endif
    do_reset();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
